// File: rtl/ifetch_unit.sv
// Instruction fetch stage: requests the word at pc from instruction memory,
// holds it for downstream with its PC tag, and refetches when pc moves away.
module ifetch_unit #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 32
) (
  input  logic          clk,
  input  logic          rstd,
  input  logic [31:0]   pc,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [31:0]   ir_pc,
  output logic [5:0]    op,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    rd,
  output logic [31:0]   imm_dpl,
  output logic [25:0]   addr,
  output logic          fetch_err,
  output logic [CW-1:0] fetch_count,
  output logic [1:0]    state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [31:0]   instr;
  logic [31:0]   req_pc;
  logic [TW-1:0] tcnt;

  // imem_req and imem_addr decode straight from state so that an
  // asynchronous reset withdraws the request without waiting for an edge.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = 32'd0;
    if (state == REQ) begin
      imem_req  = 1'b1;
      imem_addr = pc;
    end else if (state == WAIT) begin
      imem_req  = 1'b1;
      imem_addr = req_pc;
    end
  end

  // Downstream handshake: an instruction transfers on any rising edge where
  // ir_valid and ir_ready are both high; ir_valid never drops without either
  // that transfer or the pc moving away from ir_pc.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state       <= IDLE;
      instr       <= 32'd0;
      req_pc      <= 32'd0;
      ir_pc       <= 32'hFFFF_FFFF;
      ir_valid    <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_count <= '0;
      tcnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!ir_valid || pc != ir_pc) state <= REQ;
        end
        REQ: begin
          req_pc <= pc;
          tcnt   <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (imem_ack) begin
            // A pc move in the ack cycle makes the returned word stale.
            if (pc == req_pc) begin
              instr    <= imem_rdata;
              ir_pc    <= req_pc;
              ir_valid <= 1'b1;
              state    <= HOLD;
            end else begin
              state <= REQ;
            end
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            fetch_err <= 1'b1;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        HOLD: begin
          if (ir_ready) begin
            fetch_count <= fetch_count + 1'b1;
            ir_valid    <= 1'b0;
            state       <= IDLE;
          end else if (pc != ir_pc) begin
            ir_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign op      = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign imm_dpl = {{16{instr[15]}}, instr[15:0]};
  assign addr    = instr[25:0];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: fetch latency, hold/accept, stale-ack
// discard, timeout and asynchronous reset.
module tb_ifetch_unit;

  logic        clk;
  logic        rstd;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_pc;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] imm_dpl;
  logic [25:0] addr;
  logic        fetch_err;
  logic [31:0] fetch_count;
  logic [1:0]  state;

  int n_checks;
  int n_pass;
  int req_cycles;

  ifetch_unit #(.TIMEOUT(255), .CW(32)) dut (
    .clk         (clk),
    .rstd        (rstd),
    .pc          (pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .ir_pc       (ir_pc),
    .op          (op),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm_dpl     (imm_dpl),
    .addr        (addr),
    .fetch_err   (fetch_err),
    .fetch_count (fetch_count),
    .state       (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rstd       = 1'b0;
    pc         = 32'd0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    ir_ready   = 1'b0;
    tick();
    tick();

    check("rst_req",    {31'd0, imem_req},  32'd0);
    check("rst_addr",   imem_addr,          32'd0);
    check("rst_valid",  {31'd0, ir_valid},  32'd0);
    check("rst_ir_pc",  ir_pc,              32'hFFFF_FFFF);
    check("rst_err",    {31'd0, fetch_err}, 32'd0);
    check("rst_count",  fetch_count,        32'd0);
    check("rst_op",     {26'd0, op},        32'd0);
    check("rst_imm",    imm_dpl,            32'd0);
    check("rst_state",  {30'd0, state},     32'd0);
    rstd = 1'b1;

    // basic fetch at pc=0, ack on first WAIT cycle
    tick();
    check("f0_req",   {31'd0, imem_req}, 32'd1);
    check("f0_addr",  imem_addr,         32'd0);
    check("f0_state", {30'd0, state},    32'd1);
    tick();
    check("f0_wait_req", {31'd0, imem_req}, 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h8C22_FFFC;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check("f0_valid", {31'd0, ir_valid}, 32'd1);
    check("f0_op",    {26'd0, op},       32'h23);
    check("f0_rs",    {27'd0, rs},       32'd1);
    check("f0_rt",    {27'd0, rt},       32'd2);
    check("f0_rd",    {27'd0, rd},       32'd31);
    check("f0_imm",   imm_dpl,           32'hFFFF_FFFC);
    check("f0_addr26", {6'd0, addr},     32'h022_FFFC);
    check("f0_ir_pc", ir_pc,             32'd0);
    check("f0_req_drop", {31'd0, imem_req}, 32'd0);

    // stall downstream for 5 cycles
    for (int i = 0; i < 5; i++) tick();
    check("hold_valid", {31'd0, ir_valid}, 32'd1);
    check("hold_op",    {26'd0, op},       32'h23);
    check("hold_imm",   imm_dpl,           32'hFFFF_FFFC);
    check("hold_count", fetch_count,       32'd0);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    check("acc_count", fetch_count,       32'd1);
    check("acc_valid", {31'd0, ir_valid}, 32'd0);

    // pc moves 4 -> 9 during WAIT, ack arrives after the move
    pc = 32'd4;
    tick();
    check("p4_addr", imem_addr, 32'd4);
    tick();
    pc = 32'd9;
    tick();
    check("p4_wait_addr", imem_addr, 32'd4);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack   = 1'b0;
    check("p9_drop_valid", {31'd0, ir_valid}, 32'd0);
    check("p9_reissue",    {31'd0, imem_req}, 32'd1);
    check("p9_addr",       imem_addr,         32'd9);
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'h0109_5020;
    tick();
    imem_ack   = 1'b0;
    check("p9_valid", {31'd0, ir_valid}, 32'd1);
    check("p9_ir_pc", ir_pc,             32'd9);
    check("p9_rs",    {27'd0, rs},       32'd8);
    check("p9_rt",    {27'd0, rt},       32'd9);
    check("p9_rd",    {27'd0, rd},       32'd10);
    check("p9_imm",   imm_dpl,           32'h0000_5020);

    // pc change while holding: drop without counting
    pc = 32'd12;
    tick();
    check("p12_drop_valid", {31'd0, ir_valid}, 32'd0);
    check("p12_count",      fetch_count,       32'd1);
    tick();
    check("p12_addr", imem_addr, 32'd12);
    tick();
    // ack and pc change in the same cycle
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    pc         = 32'd16;
    tick();
    imem_ack   = 1'b0;
    check("same_valid", {31'd0, ir_valid}, 32'd0);
    check("same_state", {30'd0, state},    32'd1);
    check("same_addr",  imem_addr,         32'd16);
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'h3C01_8000;
    tick();
    imem_ack   = 1'b0;
    check("p16_valid", {31'd0, ir_valid}, 32'd1);
    check("p16_ir_pc", ir_pc,             32'd16);
    check("p16_op",    {26'd0, op},       32'h0F);
    check("p16_imm",   imm_dpl,           32'hFFFF_8000);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    check("p16_count", fetch_count, 32'd2);

    // timeout: REQ cycle plus 255 WAIT cycles with no ack
    pc = 32'd20;
    tick();
    check("to_req", {31'd0, imem_req}, 32'd1);
    req_cycles = 1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (imem_req) req_cycles++;
      else break;
    end
    check("to_req_cycles", req_cycles,             32'd256);
    check("to_err",        {31'd0, fetch_err},     32'd1);
    check("to_state",      {30'd0, state},         32'd0);
    tick();
    check("to_refetch",      {31'd0, imem_req},  32'd1);
    check("to_refetch_addr", imem_addr,          32'd20);
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'h8C22_FFFC;
    tick();
    imem_ack   = 1'b0;
    check("to_valid",     {31'd0, ir_valid},  32'd1);
    check("to_ir_pc",     ir_pc,              32'd20);
    check("to_err_stick", {31'd0, fetch_err}, 32'd1);

    // asynchronous reset in the middle of WAIT
    pc = 32'd24;
    tick();
    tick();
    tick();
    check("ar_wait_req", {31'd0, imem_req}, 32'd1);
    #2;
    rstd = 1'b0;
    #1;
    check("ar_req_drop", {31'd0, imem_req},  32'd0);
    check("ar_ir_pc",    ir_pc,              32'hFFFF_FFFF);
    check("ar_count",    fetch_count,        32'd0);
    check("ar_err",      {31'd0, fetch_err}, 32'd0);
    tick();
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'hAAAA_5555;
    tick();
    imem_ack   = 1'b0;
    check("ar_late_valid", {31'd0, ir_valid}, 32'd0);
    check("ar_late_ir_pc", ir_pc,             32'hFFFF_FFFF);
    check("ar_late_op",    {26'd0, op},       32'd0);
    rstd = 1'b1;
    tick();
    check("ar_restart_req",  {31'd0, imem_req}, 32'd1);
    check("ar_restart_addr", imem_addr,         32'd24);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
